// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm buzzer pattern generator.
package alarm_pkg;

  // Default widths: beep/burst counts and tick-length counts.
  localparam int unsigned CwDefault = 5;
  localparam int unsigned TwDefault = 8;

  // A burst count of this value means repeat until stopped.
  localparam int unsigned InfiniteBursts = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StOff  = 2'd2,
    StGap  = 2'd3
  } state_e;

endpackage

// File: rtl/alarm_down_cnt.sv
// Loadable down-counter that saturates at 1; flags when it holds exactly 1.
module alarm_down_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         is_one
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; never step below 1 so active phases cannot underflow.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q > W'(1))) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value  = cnt_q;
  assign is_one = (cnt_q == W'(1));

endmodule

// File: rtl/alarm_beep_seq.sv
// Alarm buzzer pattern generator: bursts of beeps with programmable on/off/gap lengths.
module alarm_beep_seq import alarm_pkg::*; #(
  parameter int unsigned CW = CwDefault,
  parameter int unsigned TW = TwDefault
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] beeps,
  input  logic [CW-1:0] bursts,
  input  logic [TW-1:0] on_ticks,
  input  logic [TW-1:0] off_ticks,
  input  logic [TW-1:0] gap_ticks,
  output logic          buzz,
  output logic          busy,
  output logic          burst_done,
  output logic          done
);

  state_e state_q, state_d;
  logic   buzz_q, buzz_d;
  logic   burst_done_q, burst_done_d;
  logic   done_q, done_d;
  logic   cfg_ld;

  // Configuration captured at start; zero lengths/counts are stored as 1.
  logic [TW-1:0] on_q, off_q, gap_q;
  logic [CW-1:0] beeps_q;

  logic          tcnt_ld, tcnt_dec, tcnt_one;
  logic [TW-1:0] tcnt_val, tcnt_unused;
  logic          bcnt_ld, bcnt_dec, bcnt_one;
  logic [CW-1:0] bcnt_val, bcnt_unused;
  logic          rcnt_ld, rcnt_dec, rcnt_one;
  logic [CW-1:0] rcnt;
  logic          infinite;

  // rcnt only ever holds 0 when the pattern was started with bursts == 0.
  assign infinite = (rcnt == CW'(InfiniteBursts));

  alarm_down_cnt #(.W(TW)) u_tcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (tcnt_ld),
    .load_val (tcnt_val),
    .dec      (tcnt_dec),
    .value    (tcnt_unused),
    .is_one   (tcnt_one)
  );

  alarm_down_cnt #(.W(CW)) u_bcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bcnt_ld),
    .load_val (bcnt_val),
    .dec      (bcnt_dec),
    .value    (bcnt_unused),
    .is_one   (bcnt_one)
  );

  alarm_down_cnt #(.W(CW)) u_rcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rcnt_ld),
    .load_val (bursts),
    .dec      (rcnt_dec),
    .value    (rcnt),
    .is_one   (rcnt_one)
  );

  // Next-state, counter control and output pulses; stop overrides everything.
  always_comb begin
    state_d      = state_q;
    burst_done_d = 1'b0;
    done_d       = 1'b0;
    cfg_ld       = 1'b0;
    tcnt_ld      = 1'b0;
    tcnt_dec     = 1'b0;
    tcnt_val     = on_q;
    bcnt_ld      = 1'b0;
    bcnt_dec     = 1'b0;
    bcnt_val     = beeps_q;
    rcnt_ld      = 1'b0;
    rcnt_dec     = 1'b0;
    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d  = StOn;
            cfg_ld   = 1'b1;
            tcnt_ld  = 1'b1;
            tcnt_val = (on_ticks == '0) ? TW'(1) : on_ticks;
            bcnt_ld  = 1'b1;
            bcnt_val = (beeps == '0) ? CW'(1) : beeps;
            rcnt_ld  = 1'b1;
          end
        end
        StOn: begin
          if (tick) begin
            if (!tcnt_one) begin
              tcnt_dec = 1'b1;
            end else if (bcnt_one) begin
              state_d      = StGap;
              tcnt_ld      = 1'b1;
              tcnt_val     = gap_q;
              burst_done_d = 1'b1;
            end else begin
              state_d  = StOff;
              tcnt_ld  = 1'b1;
              tcnt_val = off_q;
              bcnt_dec = 1'b1;
            end
          end
        end
        StOff: begin
          if (tick) begin
            if (!tcnt_one) begin
              tcnt_dec = 1'b1;
            end else begin
              state_d = StOn;
              tcnt_ld = 1'b1;
            end
          end
        end
        StGap: begin
          if (tick) begin
            if (!tcnt_one) begin
              tcnt_dec = 1'b1;
            end else if (!infinite && rcnt_one) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d  = StOn;
              tcnt_ld  = 1'b1;
              bcnt_ld  = 1'b1;
              rcnt_dec = !infinite;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    buzz_d = (state_d == StOn);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      buzz_q       <= 1'b0;
      burst_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      buzz_q       <= buzz_d;
      burst_done_q <= burst_done_d;
      done_q       <= done_d;
    end
  end

  // Configuration latch, written only on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_q    <= '0;
      off_q   <= '0;
      gap_q   <= '0;
      beeps_q <= '0;
    end else if (cfg_ld) begin
      on_q    <= (on_ticks == '0) ? TW'(1) : on_ticks;
      off_q   <= (off_ticks == '0) ? TW'(1) : off_ticks;
      gap_q   <= (gap_ticks == '0) ? TW'(1) : gap_ticks;
      beeps_q <= (beeps == '0) ? CW'(1) : beeps;
    end
  end

  assign buzz       = buzz_q;
  assign busy       = (state_q != StIdle);
  assign burst_done = burst_done_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alarm_beep_seq.sv
// Directed bench for alarm_beep_seq; tick strobes once every 4 clocks.
module tb_alarm_beep_seq;

  logic       clk = 1'b0;
  logic       rst, tick, start, stop;
  logic [4:0] beeps, bursts;
  logic [7:0] on_ticks, off_ticks, gap_ticks;
  logic       buzz, busy, burst_done, done;

  int checks = 0;
  int errors = 0;

  // Event tallies kept by the monitor.
  int   rises = 0, falls = 0, len_sum = 0, cur_len = 0, bd_cnt = 0, dn_cnt = 0;
  logic buzz_prev = 1'b0;

  alarm_beep_seq #(.CW(5), .TW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .beeps      (beeps),
    .bursts     (bursts),
    .on_ticks   (on_ticks),
    .off_ticks  (off_ticks),
    .gap_ticks  (gap_ticks),
    .buzz       (buzz),
    .busy       (busy),
    .burst_done (burst_done),
    .done       (done)
  );

  initial forever #5 clk = ~clk;

  // Time-base: one-cycle strobe every fourth clock, changed 1 time unit after the edge.
  initial begin
    int ph;
    ph   = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (ph == 3);
      ph   = (ph + 1) % 4;
    end
  end

  // Count buzz edges, buzz-high lengths and output pulses mid-cycle.
  always @(negedge clk) begin
    if (buzz === 1'b1) begin
      cur_len = cur_len + 1;
      if (buzz_prev !== 1'b1) rises = rises + 1;
    end else if (buzz_prev === 1'b1) begin
      falls   = falls + 1;
      len_sum = len_sum + cur_len;
      cur_len = 0;
    end
    buzz_prev = buzz;
    if (burst_done === 1'b1) bd_cnt = bd_cnt + 1;
    if (done === 1'b1) dn_cnt = dn_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start in a tick cycle so the start edge coincides with a tick edge.
  task automatic run_start();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n = n + 1;
    end while (tick !== 1'b1 && n < 8);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  // Cycles from the start edge (or current point) until done is seen; 400 = timed out.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #2;
      cyc = cyc + 1;
    end
  endtask

  task automatic set_cfg(input logic [4:0] b, input logic [4:0] r, input logic [7:0] on,
                         input logic [7:0] off, input logic [7:0] gap);
    beeps     = b;
    bursts    = r;
    on_ticks  = on;
    off_ticks = off;
    gap_ticks = gap;
  endtask

  initial begin
    int cyc, r0, f0, l0, b0, d0, n;
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    set_cfg(5'd3, 5'd2, 8'd2, 8'd1, 8'd5);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_buzz", 32'(buzz), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_burst_done", 32'(burst_done), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Two bursts of three 2-tick beeps: 2 bursts * (2+1+2+1+2+5) ticks * 4 clk = 104.
    r0 = rises; f0 = falls; l0 = len_sum; b0 = bd_cnt; d0 = dn_cnt;
    run_start();
    chk("t1_busy_rise", 32'(busy), 32'd1);
    chk("t1_buzz_rise", 32'(buzz), 32'd1);
    wait_done(cyc);
    chk("t1_done_cyc", 32'(cyc), 32'd104);
    chk("t1_busy_low", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #2;
    chk("t1_rises", 32'(rises - r0), 32'd6);
    chk("t1_falls", 32'(falls - f0), 32'd6);
    chk("t1_len_sum", 32'(len_sum - l0), 32'd48);
    chk("t1_burst_done", 32'(bd_cnt - b0), 32'd2);
    chk("t1_done_cnt", 32'(dn_cnt - d0), 32'd1);

    // Zero beeps/on treated as 1: one 1-tick beep, 2-tick gap, done at 12 clk.
    set_cfg(5'd0, 5'd1, 8'd0, 8'd1, 8'd2);
    r0 = rises; l0 = len_sum; b0 = bd_cnt; d0 = dn_cnt;
    run_start();
    wait_done(cyc);
    chk("t2_done_cyc", 32'(cyc), 32'd12);
    repeat (3) @(posedge clk);
    #2;
    chk("t2_rises", 32'(rises - r0), 32'd1);
    chk("t2_len_sum", 32'(len_sum - l0), 32'd4);
    chk("t2_burst_done", 32'(bd_cnt - b0), 32'd1);
    chk("t2_done_cnt", 32'(dn_cnt - d0), 32'd1);

    // Infinite repeat: 4-tick bursts, burst_done at clk 12+16j, 12 of them in 200 clk.
    set_cfg(5'd2, 5'd0, 8'd1, 8'd1, 8'd1);
    b0 = bd_cnt; d0 = dn_cnt;
    run_start();
    repeat (200) @(posedge clk);
    #2;
    chk("t3_burst_done", 32'(bd_cnt - b0), 32'd12);
    chk("t3_no_done", 32'(dn_cnt - d0), 32'd0);
    chk("t3_still_busy", 32'(busy), 32'd1);
    n = 0;
    while (buzz !== 1'b1 && n < 20) begin
      @(posedge clk);
      #2;
      n = n + 1;
    end
    chk("t3_in_on", 32'(buzz), 32'd1);
    stop = 1'b1;
    @(posedge clk);
    #2;
    stop = 1'b0;
    chk("t3_stop_buzz", 32'(buzz), 32'd0);
    chk("t3_stop_busy", 32'(busy), 32'd0);
    chk("t3_stop_done", 32'(done), 32'd0);
    repeat (8) @(posedge clk);
    #2;
    chk("t3_after_stop_done", 32'(dn_cnt - d0), 32'd0);
    chk("t3_after_stop_busy", 32'(busy), 32'd0);

    // start with stop in IDLE is ignored.
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    stop  = 1'b0;
    chk("t4_ss_busy", 32'(busy), 32'd0);
    chk("t4_ss_buzz", 32'(buzz), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    chk("t4_ss_busy_later", 32'(busy), 32'd0);

    // start while busy is ignored: 1 beep of 2 ticks + 1 tick gap = 12 clk regardless.
    set_cfg(5'd1, 5'd1, 8'd2, 8'd1, 8'd1);
    r0 = rises;
    run_start();
    repeat (4) @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(cyc);
    chk("t4_done_cyc", 32'(cyc + 5), 32'd12);
    repeat (2) @(posedge clk);
    #2;
    chk("t4_rises", 32'(rises - r0), 32'd1);

    // Async reset mid-OFF clears outputs before the next edge.
    set_cfg(5'd3, 5'd1, 8'd2, 8'd2, 8'd1);
    d0 = dn_cnt;
    run_start();
    n = 0;
    while (buzz !== 1'b0 && n < 20) begin
      @(posedge clk);
      #2;
      n = n + 1;
    end
    chk("t5_in_off", 32'({busy, buzz}), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_buzz", 32'(buzz), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_burst_done", 32'(burst_done), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    #1;
    rst = 1'b0;
    set_cfg(5'd1, 5'd1, 8'd1, 8'd1, 8'd1);
    r0 = rises;
    run_start();
    wait_done(cyc);
    chk("t5_fresh_done_cyc", 32'(cyc), 32'd8);
    repeat (2) @(posedge clk);
    #2;
    chk("t5_fresh_rises", 32'(rises - r0), 32'd1);
    chk("t5_done_cnt", 32'(dn_cnt - d0), 32'd1);

    // on_ticks changed while busy only affects the next start.
    set_cfg(5'd1, 5'd1, 8'd2, 8'd1, 8'd1);
    l0 = len_sum;
    run_start();
    on_ticks = 8'd7;
    wait_done(cyc);
    chk("t6_old_cfg_cyc", 32'(cyc), 32'd12);
    repeat (2) @(posedge clk);
    #2;
    chk("t6_old_len", 32'(len_sum - l0), 32'd8);
    l0 = len_sum;
    run_start();
    wait_done(cyc);
    chk("t6_new_cfg_cyc", 32'(cyc), 32'd32);
    repeat (2) @(posedge clk);
    #2;
    chk("t6_new_len", 32'(len_sum - l0), 32'd28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
